// File: rtl/vivaldi_pkg.sv
// vivaldi_pkg: shared types and constants for the vivaldi pattern sequencer.
package vivaldi_pkg;
  localparam int GAIN_MAX = 100;
  // Stored step field widths; the sequencer's PHASE_W/DUR_W default to these and resize at the ports.
  localparam int STEP_PHASE_W = 24;
  localparam int STEP_DUR_W = 16;
  typedef enum logic [1:0] {SINE, SQUARE, TRIANGLE, SAWTOOTH} wave_e;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} seq_state_e;
  typedef struct packed {
    wave_e wave;
    logic [STEP_PHASE_W-1:0] phase_inc;
    logic [6:0] gain;
    logic [STEP_DUR_W-1:0] dur;
  } step_t;
  function automatic logic [6:0] sat_gain(input logic [6:0] g);
    return (g > 7'(GAIN_MAX)) ? 7'(GAIN_MAX) : g;
  endfunction
endpackage

// File: rtl/vivaldi_step_ram.sv
// vivaldi_step_ram: DEPTH x step_t pattern store, one write port, registered read, no reset.
module vivaldi_step_ram
  import vivaldi_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  step_t         wd,
  input  logic [AW-1:0] ra,
  output step_t         rd
);
  step_t mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/vivaldi_sequencer.sv
// vivaldi_sequencer: steps through a programmed note pattern, driving oscillator
// waveform, pitch and gain once per step duration counted in sample ticks.
module vivaldi_sequencer
  import vivaldi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PHASE_W = 24,
  parameter int DUR_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [1:0]         wr_wave_i,
  input  logic [PHASE_W-1:0] wr_phase_inc_i,
  input  logic [6:0]         wr_gain_i,
  input  logic [DUR_W-1:0]   wr_dur_i,
  input  logic [AW:0]        length_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_i,
  input  logic               sample_tick_i,
  output logic [1:0]         wave_sel_o,
  output logic [PHASE_W-1:0] phase_inc_o,
  output logic [6:0]         gain_o,
  output logic [AW-1:0]      step_o,
  output logic               busy_o,
  output logic               note_start_o,
  output logic               done_o
);
  seq_state_e state, state_d;
  logic [AW-1:0] step_d;
  logic [AW:0] len_r;
  logic [DUR_W-1:0] dur_r, cnt;
  logic [DUR_W:0] cnt_n, dur_eff;
  logic len_ok, last, note_end;
  step_t wr_step, rd;

  assign wr_step = '{wave: wave_e'(wr_wave_i), phase_inc: STEP_PHASE_W'(wr_phase_inc_i),
                     gain: wr_gain_i, dur: STEP_DUR_W'(wr_dur_i)};

  // Read address follows the step about to be entered, so its entry is ready during LOAD.
  vivaldi_step_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i (clk_i),
    .we    (wr_en_i),
    .wa    (wr_addr_i),
    .wd    (wr_step),
    .ra    (step_d),
    .rd    (rd)
  );

  assign len_ok = (length_i != '0) && (length_i <= (AW+1)'(DEPTH));
  assign last = {1'b0, step_o} == len_r - (AW+1)'(1);
  assign cnt_n = {1'b0, cnt} + {{DUR_W{1'b0}}, sample_tick_i};
  assign dur_eff = (dur_r == '0) ? (DUR_W+1)'(1) : {1'b0, dur_r};
  // cnt can already equal dur_eff on entering PLAY when a tick landed in LOAD.
  assign note_end = (state == PLAY) && (cnt_n >= dur_eff);
  assign busy_o = (state == LOAD) || (state == PLAY);
  assign done_o = state == DONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    step_d = step_o;
    if (stop_i) state_d = IDLE;
    else
      case (state)
        IDLE: if (start_i && len_ok) begin
          state_d = LOAD;
          step_d = '0;
        end
        LOAD: state_d = PLAY;
        PLAY: if (note_end) begin
          state_d = (!last || loop_i) ? LOAD : DONE;
          step_d = !last ? step_o + AW'(1) : loop_i ? '0 : step_o;
        end
        default: state_d = IDLE;
      endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_o <= '0;
      wave_sel_o <= '0;
      phase_inc_o <= '0;
      gain_o <= '0;
      note_start_o <= 1'b0;
      len_r <= '0;
      dur_r <= '0;
      cnt <= '0;
    end else begin
      step_o <= step_d;
      note_start_o <= (state == LOAD) && !stop_i;
      if (state == IDLE && state_d == LOAD) len_r <= length_i;
      if (state == LOAD && !stop_i) begin
        wave_sel_o <= rd.wave;
        phase_inc_o <= PHASE_W'(rd.phase_inc);
        gain_o <= sat_gain(rd.gain);
        dur_r <= DUR_W'(rd.dur);
      end else if (state_d == IDLE || state_d == DONE) gain_o <= '0;
      cnt <= (state == LOAD) ? DUR_W'(sample_tick_i) :
             (state == PLAY && sample_tick_i) ? cnt_n[DUR_W-1:0] : cnt;
    end
  end
endmodule

// File: tb/tb_vivaldi_sequencer.sv
// tb_vivaldi_sequencer: directed self-checking bench for vivaldi_sequencer.
module tb_vivaldi_sequencer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic wr_en_i = 1'b0;
  logic [3:0] wr_addr_i = '0;
  logic [1:0] wr_wave_i = '0;
  logic [23:0] wr_phase_inc_i = '0;
  logic [6:0] wr_gain_i = '0;
  logic [15:0] wr_dur_i = '0;
  logic [4:0] length_i = '0;
  logic start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0, sample_tick_i = 1'b0;
  logic [1:0] wave_sel_o;
  logic [23:0] phase_inc_o;
  logic [6:0] gain_o;
  logic [3:0] step_o;
  logic busy_o, note_start_o, done_o;
  int errors = 0, checks = 0, ns_cnt = 0, dn_cnt = 0;

  vivaldi_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_wave_i(wr_wave_i), .wr_phase_inc_i(wr_phase_inc_i), .wr_gain_i(wr_gain_i),
    .wr_dur_i(wr_dur_i), .length_i(length_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .sample_tick_i(sample_tick_i), .wave_sel_o(wave_sel_o),
    .phase_inc_o(phase_inc_o), .gain_o(gain_o), .step_o(step_o), .busy_o(busy_o),
    .note_start_o(note_start_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    ns_cnt += int'(note_start_o);
    dn_cnt += int'(done_o);
  endtask

  task automatic tick();
    sample_tick_i = 1'b1;
    cyc();
    sample_tick_i = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] w, input logic [23:0] p,
                    input logic [6:0] g, input logic [15:0] d);
    wr_en_i = 1'b1;
    wr_addr_i = a;
    wr_wave_i = w;
    wr_phase_inc_i = p;
    wr_gain_i = g;
    wr_dur_i = d;
    cyc();
    wr_en_i = 1'b0;
  endtask

  task automatic go(input logic [4:0] len);
    length_i = len;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cyc();
  endtask

  initial begin
    int exp_step [16] = '{0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0};
    int n;
    cyc();
    cyc();
    check("rst_step", step_o, 0);
    check("rst_gain", gain_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0;
    cyc();
    // three-step pattern, single pass
    wr(0, 0, 1000, 50, 4);
    wr(1, 1, 2000, 80, 2);
    wr(2, 3, 3000, 100, 1);
    ns_cnt = 0;
    dn_cnt = 0;
    go(3);
    check("p1_note_start", note_start_o, 1);
    check("p1_step0", step_o, 0);
    check("p1_phase0", phase_inc_o, 1000);
    check("p1_gain0", gain_o, 50);
    check("p1_wave0", wave_sel_o, 0);
    check("p1_busy", busy_o, 1);
    tick();
    tick();
    tick();
    check("p1_step0_hold", step_o, 0);
    tick();
    check("p1_step1", step_o, 1);
    check("p1_phase1", phase_inc_o, 2000);
    check("p1_gain1", gain_o, 80);
    check("p1_wave1", wave_sel_o, 1);
    length_i = 1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("busy_start_ignored", step_o, 1);
    tick();
    tick();
    check("p1_step2", step_o, 2);
    check("p1_gain2", gain_o, 100);
    check("p1_wave2", wave_sel_o, 3);
    check("p1_no_done_yet", dn_cnt, 0);
    tick();
    check("p1_note_starts", ns_cnt, 3);
    check("p1_done_pulses", dn_cnt, 1);
    check("p1_gain_after", gain_o, 0);
    check("p1_busy_after", busy_o, 0);
    check("p1_phase_hold", phase_inc_o, 3000);
    // looping playback, then clear loop mid-pass
    loop_i = 1'b1;
    dn_cnt = 0;
    go(3);
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("loop_step_%0d", k + 1), step_o, exp_step[k]);
    end
    check("loop_no_done", dn_cnt, 0);
    loop_i = 1'b0;
    n = 0;
    while (dn_cnt == 0 && n < 10) begin
      tick();
      n++;
    end
    check("unloop_ticks", n, 5);
    check("unloop_done", dn_cnt, 1);
    // dur=0 and saturated gain
    wr(0, 2, 4000, 120, 0);
    dn_cnt = 0;
    go(1);
    check("sat_gain", gain_o, 100);
    check("sat_wave", wave_sel_o, 2);
    tick();
    check("dur0_done", dn_cnt, 1);
    // tick during LOAD counts as the first tick
    dn_cnt = 0;
    length_i = 1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    sample_tick_i = 1'b1;
    cyc();
    sample_tick_i = 1'b0;
    cyc();
    check("load_tick_done", dn_cnt, 1);
    cyc();
    wr(0, 0, 1000, 50, 4);
    // stop with start and tick mid-note
    dn_cnt = 0;
    go(3);
    tick();
    tick();
    stop_i = 1'b1;
    start_i = 1'b1;
    sample_tick_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    start_i = 1'b0;
    sample_tick_i = 1'b0;
    check("stop_busy", busy_o, 0);
    check("stop_gain", gain_o, 0);
    check("stop_done", done_o, 0);
    cyc();
    cyc();
    check("stop_no_done", dn_cnt, 0);
    ns_cnt = 0;
    go(3);
    check("restart_step", step_o, 0);
    check("restart_phase", phase_inc_o, 1000);
    check("restart_note", ns_cnt, 1);
    // rewrite step 1 while it plays
    loop_i = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("rw_step1", step_o, 1);
    wr(1, 2, 5555, 20, 2);
    check("rw_phase_hold", phase_inc_o, 2000);
    check("rw_gain_hold", gain_o, 80);
    tick();
    check("rw_phase_hold2", phase_inc_o, 2000);
    check("rw_wave_hold2", wave_sel_o, 1);
    for (int k = 0; k < 6; k++) tick();
    check("rw_new_step", step_o, 1);
    check("rw_new_phase", phase_inc_o, 5555);
    check("rw_new_gain", gain_o, 20);
    check("rw_new_wave", wave_sel_o, 2);
    // asynchronous reset mid-PLAY
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_step", step_o, 0);
    check("arst_wave", wave_sel_o, 0);
    check("arst_phase", phase_inc_o, 0);
    check("arst_gain", gain_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_note", note_start_o, 0);
    check("arst_done", done_o, 0);
    cyc();
    length_i = 0;
    start_i = 1'b1;
    rst_i = 1'b0;
    cyc();
    cyc();
    check("len0_idle", busy_o, 0);
    length_i = 17;
    cyc();
    cyc();
    check("len17_idle", busy_o, 0);
    start_i = 1'b0;
    cyc();
    go(16);
    check("len16_busy", busy_o, 1);
    check("len16_phase", phase_inc_o, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
